// File: rtl/aes128_type_pkg.sv
// Shared types for the AES-128 host controller: register map, CTRL/STATUS
// bit positions, FSM encoding and the 128-bit block word-order helper.
package aes128_type_pkg;

    localparam logic [3:0] ADDR_KEY0   = 4'd0;
    localparam logic [3:0] ADDR_DATA0  = 4'd4;
    localparam logic [3:0] ADDR_CTRL   = 4'd8;
    localparam logic [3:0] ADDR_STATUS = 4'd9;
    localparam logic [3:0] ADDR_LAT    = 4'd10;
    localparam logic [3:0] ADDR_RSVD   = 4'd11;
    localparam logic [3:0] ADDR_RES0   = 4'd12;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_OP_BIT     = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;

    localparam logic [15:0] LAT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_START   = 3'd2,
        S_FLUSH   = 3'd3,
        S_BUSY    = 3'd4,
        S_CAPTURE = 3'd5
    } ctrl_state_e;

    // Field order puts err at bit 2, done at bit 1, busy at bit 0.
    typedef struct packed {
        logic err;
        logic done;
        logic busy;
    } status_t;

    // Register file view: index 0 is word 0 (bus address order).
    typedef logic [3:0][31:0] blk_t;

    // Word 0 lives at [127:96] on the core bus; the swap is its own inverse.
    function automatic blk_t word_swap(input blk_t b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

endpackage

// File: rtl/aes128_host_ctrl.sv
// Bus-register front end for an external AES-128 core: holds key/data,
// sequences one operation per start write and captures the result.
module aes128_host_ctrl
    import aes128_type_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [3:0]   addr_i,
    input  logic         wr_en_i,
    input  logic [31:0]  wr_data_i,
    output logic [31:0]  rd_data_o,
    output logic         irq_o,
    output logic         core_start_o,
    output logic [1:0]   core_op_o,
    output logic [127:0] core_key_o,
    output logic [127:0] core_data_o,
    input  logic [127:0] core_result_i,
    input  logic         core_valid_i,
    input  logic         core_ready_i
);

    ctrl_state_e state_q, state_d;
    blk_t        key_q, key_d;
    blk_t        data_q, data_d;
    blk_t        res_q, res_d;
    logic        op_q, op_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        start_q, start_d;
    logic        irq_q, irq_d;
    logic [15:0] lat_q, lat_d;

    logic    busy;
    logic    wr_key, wr_blk, wr_ctrl, wr_status;
    logic    start_acc, set_err;
    status_t stat;

    assign busy = (state_q != S_IDLE);
    assign stat = {err_q, done_q, busy};

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        data_d    = data_q;
        res_d     = res_q;
        op_d      = op_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        err_d     = err_q;
        lat_d     = lat_q;
        start_d   = 1'b0;
        set_err   = 1'b0;

        wr_key    = wr_en_i && (addr_i[3:2] == 2'b00);
        wr_blk    = wr_en_i && (addr_i[3:2] == 2'b01);
        wr_ctrl   = wr_en_i && (addr_i == ADDR_CTRL);
        wr_status = wr_en_i && (addr_i == ADDR_STATUS);
        start_acc = wr_ctrl && wr_data_i[CTRL_START_BIT] && !busy;

        // Operands are frozen for the whole operation so the core sees stable inputs.
        if (wr_key) begin
            if (!busy) key_d[addr_i[1:0]] = wr_data_i;
            else       set_err = 1'b1;
        end
        if (wr_blk) begin
            if (!busy) data_d[addr_i[1:0]] = wr_data_i;
            else       set_err = 1'b1;
        end
        if (wr_ctrl) begin
            irq_en_d = wr_data_i[CTRL_IRQ_EN_BIT];
            if (!busy) op_d = wr_data_i[CTRL_OP_BIT];
            else       set_err = 1'b1;
        end

        if (wr_status) begin
            if (wr_data_i[STAT_DONE_BIT]) done_d = 1'b0;
            if (wr_data_i[STAT_ERR_BIT])  err_d  = 1'b0;
        end
        if (start_acc) done_d = 1'b0;
        if (set_err)   err_d  = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start_acc) state_d = S_REQ;
            end
            S_REQ: begin
                if (core_ready_i) begin
                    state_d = S_START;
                    start_d = 1'b1;
                end
            end
            S_START: begin
                lat_d   = '0;
                state_d = S_FLUSH;
            end
            S_FLUSH: begin
                // core_valid_i may still show the previous result here; ignore it.
                if (lat_q != LAT_MAX) lat_d = lat_q + 16'd1;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (lat_q != LAT_MAX) lat_d = lat_q + 16'd1;
                if (core_valid_i) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                res_d   = word_swap(core_result_i);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        irq_d = done_d & irq_en_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            key_q    <= '0;
            data_q   <= '0;
            res_q    <= '0;
            op_q     <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            lat_q    <= '0;
            start_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            data_q   <= data_d;
            res_q    <= res_d;
            op_q     <= op_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            lat_q    <= lat_d;
            start_q  <= start_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        case (addr_i[3:2])
            2'b00: rd_data_o = key_q[addr_i[1:0]];
            2'b01: rd_data_o = data_q[addr_i[1:0]];
            2'b11: rd_data_o = res_q[addr_i[1:0]];
            default: begin
                case (addr_i[1:0])
                    2'b00: begin
                        rd_data_o[CTRL_OP_BIT]     = op_q;
                        rd_data_o[CTRL_IRQ_EN_BIT] = irq_en_q;
                    end
                    2'b01:   rd_data_o = {29'd0, stat};
                    2'b10:   rd_data_o = {16'd0, lat_q};
                    default: rd_data_o = '0;
                endcase
            end
        endcase
    end

    // Only the encrypt/decrypt bit is stored; the upper op bit is always 0.
    assign core_op_o    = {1'b0, op_q};
    assign core_start_o = start_q;
    assign core_key_o   = word_swap(key_q);
    assign core_data_o  = word_swap(data_q);
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_aes128_host_ctrl.sv
// Bench for aes128_host_ctrl: behavioural AES core stand-in plus a
// register-level reference model of the host interface.
module tb_aes128_host_ctrl;
    import aes128_type_pkg::*;

    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   addr = 4'd0;
    logic         wr_en = 1'b0;
    logic [31:0]  wr_data = 32'd0;
    logic [31:0]  rd_data;
    logic         irq;
    logic         core_start;
    logic [1:0]   core_op;
    logic [127:0] core_key, core_data;
    logic [127:0] core_result;
    logic         core_valid;
    logic         core_ready;

    int checks = 0;
    int errors = 0;

    aes128_host_ctrl dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .wr_en_i(wr_en),
        .wr_data_i(wr_data), .rd_data_o(rd_data), .irq_o(irq),
        .core_start_o(core_start), .core_op_o(core_op),
        .core_key_o(core_key), .core_data_o(core_data),
        .core_result_i(core_result), .core_valid_i(core_valid),
        .core_ready_i(core_ready)
    );

    always #10 clk = ~clk;

    initial begin
        #4_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    // Stand-in cipher: real FIPS-197 vector in both directions, a reversible mix otherwise.
    function automatic logic [127:0] aes_fn(input logic dec, input logic [127:0] k, input logic [127:0] d);
        if (!dec && k == FIPS_K && d == FIPS_P) return FIPS_C;
        if (dec && k == FIPS_K && d == FIPS_C) return FIPS_P;
        return d ^ {k[63:0], k[127:64]} ^ (dec ? 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0
                                              : 128'h5a5aa5a5c3c33c3c96966969f00f0ff0);
    endfunction

    // Core model: result valid core_lat cycles after the start pulse, valid held until the next start.
    int           core_lat = 4;
    bit           hold_ready = 1'b0;
    bit           running;
    int           cnt;
    logic [127:0] pend;
    int           start_cnt = 0;

    assign core_ready = !running && !hold_ready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0; cnt <= 0; core_valid <= 1'b0;
            core_result <= '0; pend <= '0;
        end else if (core_start) begin
            running <= 1'b1;
            cnt     <= core_lat;
            pend    <= aes_fn(core_op != 2'd0, core_key, core_data);
        end else if (running) begin
            if (cnt <= 1) begin
                core_valid <= 1'b1; core_result <= pend; running <= 1'b0;
            end else begin
                core_valid <= 1'b0; cnt <= cnt - 1;
            end
        end
    end

    always @(posedge clk) if (core_start) start_cnt <= start_cnt + 1;

    // Reference register model.
    logic [127:0] ref_key, ref_data;
    logic         ref_op, ref_irq_en, ref_done, ref_err;
    bit           ref_idle;

    task automatic ref_reset();
        ref_key = '0; ref_data = '0; ref_op = 0; ref_irq_en = 0;
        ref_done = 0; ref_err = 0; ref_idle = 1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        int i;
        i = int'(a[1:0]);
        if (a < 4'd4) begin
            if (ref_idle) ref_key[127-32*i -: 32] = d; else ref_err = 1;
        end else if (a < 4'd8) begin
            if (ref_idle) ref_data[127-32*i -: 32] = d; else ref_err = 1;
        end else if (a == ADDR_CTRL) begin
            ref_irq_en = d[2];
            if (ref_idle) begin
                ref_op = d[1];
                if (d[0]) begin ref_idle = 0; ref_done = 0; end
            end else ref_err = 1;
        end else if (a == ADDR_STATUS) begin
            if (d[1]) ref_done = 0;
            if (d[2]) ref_err = 0;
        end
        addr = a; wr_data = d; wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        addr = a; #1; d = rd_data;
    endtask

    task automatic load_block(input logic [127:0] k, input logic [127:0] d);
        for (int i = 0; i < 4; i++) bus_write(4'(ADDR_KEY0 + i), k[127-32*i -: 32]);
        for (int i = 0; i < 4; i++) bus_write(4'(ADDR_DATA0 + i), d[127-32*i -: 32]);
    endtask

    // Waits for the start pulse, then the result; traces done over valid-cycle, +1, +2.
    task automatic complete_op(input int snap, input int budget, input bit w1c,
                               output bit to, output logic [2:0] trace);
        int n;
        logic [31:0] r;
        to = 0; trace = '0; n = 0;
        while (start_cnt == snap && n < budget) begin @(posedge clk); #1; n++; end
        if (start_cnt == snap) begin to = 1; return; end
        @(posedge clk); #1;
        n = 0;
        while (core_valid !== 1'b1 && n < budget) begin @(posedge clk); #1; n++; end
        if (core_valid !== 1'b1) begin to = 1; return; end
        rd(ADDR_STATUS, r); trace[0] = r[1];
        @(posedge clk); #1;
        rd(ADDR_STATUS, r); trace[1] = r[1];
        if (w1c) begin addr = ADDR_STATUS; wr_data = 32'h2; wr_en = 1'b1; end
        @(posedge clk); #1;
        wr_en = 1'b0;
        rd(ADDR_STATUS, r); trace[2] = r[1];
        ref_idle = 1; ref_done = 1;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rd(ADDR_KEY0, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_rd_addr0 got %h want %h", r, 32'h0); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", irq); end
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b want 0", core_start); end
        rd(ADDR_STATUS, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_status got %h want %h", r, 32'h0); end
        rd(ADDR_LAT, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_lat got %h want %h", r, 32'h0); end
        rst = 1'b0;
        ref_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_fips_encrypt();
        int snap; bit to; logic [2:0] tr; logic [31:0] r;
        core_lat = 10;
        load_block(FIPS_K, FIPS_P);
        snap = start_cnt;
        bus_write(ADDR_CTRL, 32'h1);
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL enc_start_early got %b want 0", core_start); end
        @(posedge clk); #1;
        checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL enc_start_at2 got %b want 1", core_start); end
        checks++; if (core_key !== FIPS_K) begin errors++; $display("FAIL enc_core_key got %h want %h", core_key, FIPS_K); end
        complete_op(snap, 100, 0, to, tr);
        checks++; if (to) begin errors++; $display("FAIL enc_timeout got 1 want 0"); end
        checks++; if (tr !== 3'b100) begin errors++; $display("FAIL enc_done_timing got %b want 100", tr); end
        for (int i = 0; i < 4; i++) begin
            rd(4'(ADDR_RES0 + i), r);
            checks++; if (r !== FIPS_C[127-32*i -: 32]) begin errors++; $display("FAIL enc_res%0d got %h want %h", i, r, FIPS_C[127-32*i -: 32]); end
        end
        rd(ADDR_STATUS, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL enc_status got %h want %h", r, 32'h2); end
        rd(ADDR_LAT, r);
        checks++; if (r !== 32'd11) begin errors++; $display("FAIL enc_lat got %0d want 11", r); end
    endtask

    task automatic test_fips_decrypt();
        int snap; bit to; logic [2:0] tr; logic [31:0] r;
        core_lat = 6;
        load_block(FIPS_K, FIPS_C);
        snap = start_cnt;
        bus_write(ADDR_CTRL, 32'h3);
        checks++; if (core_op !== 2'd1) begin errors++; $display("FAIL dec_core_op got %0d want 1", core_op); end
        complete_op(snap, 100, 0, to, tr);
        checks++; if (to) begin errors++; $display("FAIL dec_timeout got 1 want 0"); end
        for (int i = 0; i < 4; i++) begin
            rd(4'(ADDR_RES0 + i), r);
            checks++; if (r !== FIPS_P[127-32*i -: 32]) begin errors++; $display("FAIL dec_res%0d got %h want %h", i, r, FIPS_P[127-32*i -: 32]); end
        end
    endtask

    task automatic test_latency();
        int snap; bit to; logic [2:0] tr; logic [31:0] r;
        core_lat = 50;
        snap = start_cnt;
        bus_write(ADDR_CTRL, 32'h1);
        complete_op(snap, 200, 0, to, tr);
        checks++; if (to) begin errors++; $display("FAIL lat50_timeout got 1 want 0"); end
        rd(ADDR_LAT, r);
        checks++; if (r !== 32'd51) begin errors++; $display("FAIL lat50 got %0d want 51", r); end
        repeat (5) @(posedge clk);
        #1; rd(ADDR_LAT, r);
        checks++; if (r !== 32'd51) begin errors++; $display("FAIL lat_hold_idle got %0d want 51", r); end
        core_lat = 70000;
        snap = start_cnt;
        bus_write(ADDR_CTRL, 32'h1);
        complete_op(snap, 70100, 0, to, tr);
        checks++; if (to) begin errors++; $display("FAIL lat70k_timeout got 1 want 0"); end
        rd(ADDR_LAT, r);
        checks++; if (r !== 32'h0000ffff) begin errors++; $display("FAIL lat_saturate got %h want %h", r, 32'hffff); end
    endtask

    task automatic test_busy_writes();
        int snap; bit to; logic [2:0] tr; logic [31:0] r; logic [127:0] key_before;
        core_lat = 30;
        key_before = ref_key;
        snap = start_cnt;
        bus_write(ADDR_CTRL, 32'h1);
        bus_write(ADDR_CTRL, 32'h1);
        bus_write(ADDR_KEY0, 32'hdeadbeef);
        checks++; if (core_key !== key_before) begin errors++; $display("FAIL busy_core_key got %h want %h", core_key, key_before); end
        complete_op(snap, 100, 0, to, tr);
        checks++; if (to) begin errors++; $display("FAIL busy_timeout got 1 want 0"); end
        checks++; if (start_cnt - snap != 1) begin errors++; $display("FAIL busy_start_pulses got %0d want 1", start_cnt - snap); end
        rd(ADDR_KEY0, r);
        checks++; if (r !== ref_key[127:96]) begin errors++; $display("FAIL busy_key0 got %h want %h", r, ref_key[127:96]); end
        rd(ADDR_STATUS, r);
        checks++; if (r !== {29'd0, ref_err, ref_done, 1'b0}) begin errors++; $display("FAIL busy_err_set got %h want %h", r, {29'd0, ref_err, ref_done, 1'b0}); end
        bus_write(ADDR_STATUS, 32'h4);
        rd(ADDR_STATUS, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL busy_err_w1c got %h want %h", r, 32'h2); end
    endtask

    task automatic test_irq();
        int snap; bit to; logic [2:0] tr; logic [31:0] r;
        core_lat = 8;
        snap = start_cnt;
        bus_write(ADDR_CTRL, 32'h5);
        complete_op(snap, 100, 0, to, tr);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irq); end
        bus_write(ADDR_STATUS, 32'h2);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c got %b want 0", irq); end
        snap = start_cnt;
        bus_write(ADDR_CTRL, 32'h5);
        complete_op(snap, 100, 1, to, tr);
        checks++; if (to) begin errors++; $display("FAIL irq_timeout got 1 want 0"); end
        checks++; if (tr !== 3'b100) begin errors++; $display("FAIL irq_set_wins got %b want 100", tr); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_race got %b want 1", irq); end
        bus_write(ADDR_CTRL, 32'h0);
        rd(ADDR_STATUS, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL irq_status got %h want %h", r, 32'h2); end
    endtask

    task automatic test_reset_mid_op();
        int snap; bit to; logic [2:0] tr; logic [31:0] r;
        core_lat = 40;
        snap = start_cnt;
        bus_write(ADDR_CTRL, 32'h7);
        repeat (10) @(posedge clk);
        #1; rd(ADDR_STATUS, r);
        checks++; if (r[0] !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", r[0]); end
        rst = 1'b1;
        @(posedge clk); #1;
        addr = ADDR_KEY0; #1;
        checks++; if ({core_start, irq, core_op, core_key, core_data, rd_data} !== '0)
            begin errors++; $display("FAIL mid_outputs got %b%b %h %h %h %h want all zero", core_start, irq, core_op, core_key, core_data, rd_data); end
        rd(ADDR_STATUS, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL mid_status got %h want %h", r, 32'h0); end
        rst = 1'b0;
        ref_reset();
        @(posedge clk); #1;
        core_lat = 5;
        load_block(FIPS_K, FIPS_P);
        snap = start_cnt;
        bus_write(ADDR_CTRL, 32'h1);
        complete_op(snap, 100, 0, to, tr);
        checks++; if (to || start_cnt - snap != 1) begin errors++; $display("FAIL mid_restart got to=%0d pulses=%0d want to=0 pulses=1", to, start_cnt - snap); end
        rd(ADDR_RES0, r);
        checks++; if (r !== FIPS_C[127:96]) begin errors++; $display("FAIL mid_res0 got %h want %h", r, FIPS_C[127:96]); end
    endtask

    task automatic test_random();
        int snap, h, lat; bit to; logic [2:0] tr; logic [31:0] r; logic [127:0] k, d, e;
        logic op;
        for (int it = 0; it < 8; it++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            d = {$urandom, $urandom, $urandom, $urandom};
            op = 1'($urandom_range(0, 1));
            lat = int'($urandom_range(2, 40));
            h = int'($urandom_range(0, 4));
            core_lat = lat;
            load_block(k, d);
            hold_ready = (h != 0);
            snap = start_cnt;
            bus_write(ADDR_CTRL, {30'd0, op, 1'b1});
            checks++; if (core_op !== {1'b0, ref_op}) begin errors++; $display("FAIL rnd%0d_op got %0d want %0d", it, core_op, ref_op); end
            repeat (h) @(posedge clk);
            #1; hold_ready = 1'b0;
            complete_op(snap, 200, 0, to, tr);
            checks++; if (to || tr !== 3'b100) begin errors++; $display("FAIL rnd%0d_done got to=%0d trace=%b want to=0 trace=100", it, to, tr); end
            e = aes_fn(ref_op, ref_key, ref_data);
            for (int i = 0; i < 4; i++) begin
                rd(4'(ADDR_RES0 + i), r);
                checks++; if (r !== e[127-32*i -: 32]) begin errors++; $display("FAIL rnd%0d_res%0d got %h want %h", it, i, r, e[127-32*i -: 32]); end
            end
            rd(ADDR_LAT, r);
            checks++; if (r !== 32'(lat + 1)) begin errors++; $display("FAIL rnd%0d_lat got %0d want %0d", it, r, lat + 1); end
            rd(ADDR_STATUS, r);
            checks++; if (r !== {29'd0, ref_err, ref_done, 1'b0}) begin errors++; $display("FAIL rnd%0d_status got %h want %h", it, r, {29'd0, ref_err, ref_done, 1'b0}); end
        end
    endtask

    initial begin
        ref_reset();
        test_reset();
        test_fips_encrypt();
        test_fips_decrypt();
        test_latency();
        test_busy_writes();
        test_irq();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
